i4001_rom: RTL

4001-class ROM-and-I/O responder: the far end of the 4004 external bus. It recovers the 8-phase instruction cycle from SYNC/CLK1/CLK2, captures the 12-bit address nibbles, and returns the 8-bit opcode during M1/M2 when its chip number matches. It also services the SRC/WRR/RDR I/O-port transactions for its 4-bit port. It connects to the CPU through split data_in/data_out/data_oe pads and fetches bytes from an external 256x8 ROM array.

---
 rtl/i4001_pkg.sv | 47 ++++
 rtl/i4001_phase_tracker.sv | 58 +++++
 rtl/i4001_rom.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/i4001_pkg.sv
// Shared definitions for the 4001 ROM/I/O responder: phase encoding, I/O opcodes,
// clock edge helpers and the instruction-cycle phase sequencer.
package i4001_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    A1   = 4'd1,
    A2   = 4'd2,
    A3   = 4'd3,
    M1   = 4'd4,
    M2   = 4'd5,
    X1   = 4'd6,
    X2   = 4'd7,
    X3   = 4'd8
  } phase_t;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;

  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic edge_fall(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

  // Next phase of the 8-phase instruction cycle; IDLE only leaves via SYNC.
  function automatic phase_t phase_advance(input phase_t ph);
    phase_t nxt;
    case (ph)
      A1:      nxt = A2;
      A2:      nxt = A3;
      A3:      nxt = M1;
      M1:      nxt = M2;
      M2:      nxt = X1;
      X1:      nxt = X2;
      X2:      nxt = X3;
      X3:      nxt = A1;
      IDLE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/i4001_phase_tracker.sv
// Recovers the 4004 instruction-cycle phase from SYNC and the sampled CLK1/CLK2 levels.
module i4001_phase_tracker
  import i4001_pkg::*;
(
  input  logic   sysclk,
  input  logic   poc_n,
  input  logic   clk1,
  input  logic   clk2,
  input  logic   sync,
  output phase_t phase,
  output logic   clk1_rise,
  output logic   clk2_fall
);

  logic   clk1_d_q;
  logic   clk2_d_q;
  logic   sync_seen_q;
  logic   sync_seen_d;
  phase_t phase_q;
  phase_t phase_d;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      clk1_d_q    <= 1'b0;
      clk2_d_q    <= 1'b0;
      sync_seen_q <= 1'b0;
      phase_q     <= IDLE;
    end else begin
      clk1_d_q    <= clk1;
      clk2_d_q    <= clk2;
      sync_seen_q <= sync_seen_d;
      phase_q     <= phase_d;
    end
  end

  // A SYNC seen anywhere (or on the edge itself) restarts the cycle at A1.
  always_comb begin
    phase_d     = phase_q;
    sync_seen_d = sync_seen_q | sync;
    if (clk1_rise) begin
      if (sync_seen_q || sync) begin
        phase_d     = A1;
        sync_seen_d = 1'b0;
      end else begin
        phase_d = phase_advance(phase_q);
      end
    end else begin
      phase_d = phase_q;
    end
  end

  always_comb begin
    clk1_rise = edge_rise(clk1, clk1_d_q);
    clk2_fall = edge_fall(clk2, clk2_d_q);
    phase     = phase_q;
  end

endmodule

// File: rtl/i4001_rom.sv
// 4001-class ROM and I/O port responder on the 4004 bus: address capture, opcode
// return in M1/M2, and SRC/WRR/RDR servicing of the 4-bit port.
module i4001_rom
  import i4001_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter logic [3:0] IO_MASK = 4'hF
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  phase_t     phase_s;
  logic       clk1_rise_s;
  logic       clk2_fall_s;
  logic       rdr_s;

  logic [7:0] addr_q, addr_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic       sel_q, sel_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic       io_cyc_q, io_cyc_d;
  logic       src_sel_q, src_sel_d;
  logic [3:0] io_out_q, io_out_d;
  logic [3:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;

  i4001_phase_tracker u_tracker (
    .sysclk    (sysclk),
    .poc_n     (poc_n),
    .clk1      (clk1),
    .clk2      (clk2),
    .sync      (sync),
    .phase     (phase_s),
    .clk1_rise (clk1_rise_s),
    .clk2_fall (clk2_fall_s)
  );

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      addr_q     <= 8'h00;
      rom_addr_q <= 8'h00;
      sel_q      <= 1'b0;
      opr_q      <= 4'h0;
      opa_q      <= 4'h0;
      io_cyc_q   <= 1'b0;
      src_sel_q  <= 1'b0;
      io_out_q   <= 4'h0;
      data_out_q <= 4'h0;
      data_oe_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      sel_q      <= sel_d;
      opr_q      <= opr_d;
      opa_q      <= opa_d;
      io_cyc_q   <= io_cyc_d;
      src_sel_q  <= src_sel_d;
      io_out_q   <= io_out_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  // Bus capture on clk2_fall; the opcode is snooped whether or not this chip drove it.
  always_comb begin
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    sel_d      = sel_q;
    opr_d      = opr_q;
    opa_d      = opa_q;
    io_cyc_d   = io_cyc_q;
    src_sel_d  = src_sel_q;
    io_out_d   = io_out_q;
    if (clk2_fall_s) begin
      case (phase_s)
        A1: addr_d[3:0] = data_in;
        A2: addr_d[7:4] = data_in;
        A3: begin
          sel_d      = cm_rom & (data_in == CHIP_ID);
          rom_addr_d = addr_q;
        end
        M1: opr_d = data_in;
        M2: begin
          opa_d    = data_in;
          io_cyc_d = cm_rom & (opr_q == OPR_IO);
        end
        X2: begin
          if (cm_rom && !io_cyc_q) begin
            src_sel_d = (data_in == CHIP_ID);
          end else if (io_cyc_q && src_sel_q && (opa_q == OPA_WRR)) begin
            io_out_d = data_in & IO_MASK;
          end else begin
            src_sel_d = src_sel_q;
          end
        end
        default: addr_d = addr_q;
      endcase
    end else begin
      addr_d = addr_q;
    end
  end

  // Drive decisions follow the registered phase, so the pads lag clk1_rise by one sysclk.
  always_comb begin
    rdr_s      = io_cyc_q & src_sel_q & (opa_q == OPA_RDR);
    data_out_d = 4'h0;
    data_oe_d  = 1'b0;
    case (phase_s)
      M1: begin
        if (sel_q) begin
          data_oe_d  = 1'b1;
          data_out_d = rom_data[7:4];
        end else begin
          data_oe_d = 1'b0;
        end
      end
      M2: begin
        if (sel_q) begin
          data_oe_d  = 1'b1;
          data_out_d = rom_data[3:0];
        end else begin
          data_oe_d = 1'b0;
        end
      end
      X2: begin
        if (rdr_s) begin
          data_oe_d  = 1'b1;
          data_out_d = io_in & ~IO_MASK;
        end else begin
          data_oe_d = 1'b0;
        end
      end
      default: data_oe_d = 1'b0;
    endcase
  end

  always_comb begin
    data_out = data_out_q;
    data_oe  = data_oe_q;
    rom_addr = rom_addr_q;
    io_out   = io_out_q;
  end

endmodule
